// File: rtl/reg_writeback_pkg.sv
// Shared widths and load-queue entry layout for the register-file write-back block.
package reg_writeback_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int LQ_DEPTH = 2;

    typedef struct packed {
        logic              valid;
        logic              filled;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } lq_entry_t;

endpackage

// File: rtl/reg_writeback_lq_fifo.sv
// Two-entry in-order load queue: push at tail, fill the oldest unfilled entry, pop head.
module reg_writeback_lq_fifo
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [REG_AW-1:0] i_push_rd,
    input  logic              i_rsp_valid,
    input  logic [XLEN-1:0]   i_rsp_data,
    input  logic              i_pop,
    output logic              o_ready,
    output lq_entry_t         o_head,
    output logic              o_younger_valid,
    output logic [REG_AW-1:0] o_younger_rd,
    output logic              o_rsp_err
);

    lq_entry_t  r_q [DEPTH];
    logic       r_head;
    logic       r_tail;
    logic [1:0] r_count;

    lq_entry_t  w_young;
    logic       w_push_acc;
    logic       w_fill_head;
    logic       w_fill_young;

    assign o_ready         = (r_count != 2'(DEPTH));
    assign o_head          = r_q[r_head];
    assign w_young         = r_q[~r_head];
    assign o_younger_valid = w_young.valid;
    assign o_younger_rd    = w_young.rd;

    assign w_push_acc = i_push & o_ready;

    // Only entries present at cycle start can be filled, so a same-cycle push is never matched.
    assign w_fill_head  = i_rsp_valid & o_head.valid & ~o_head.filled;
    assign w_fill_young = i_rsp_valid & ~w_fill_head & w_young.valid & ~w_young.filled;
    assign o_rsp_err    = i_rsp_valid & ~w_fill_head & ~w_fill_young;

    // Push, fill and pop always touch distinct entries, so they can share one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i].valid  <= 1'b0;
                r_q[i].filled <= 1'b0;
            end
        end else begin
            if (w_push_acc) begin
                r_q[r_tail].valid  <= 1'b1;
                r_q[r_tail].filled <= 1'b0;
                r_q[r_tail].rd     <= i_push_rd;
                r_tail             <= ~r_tail;
            end
            if (w_fill_head) begin
                r_q[r_head].filled <= 1'b1;
                r_q[r_head].data   <= i_rsp_data;
            end
            if (w_fill_young) begin
                r_q[~r_head].filled <= 1'b1;
                r_q[~r_head].data   <= i_rsp_data;
            end
            if (i_pop) begin
                r_q[r_head].valid  <= 1'b0;
                r_q[r_head].filled <= 1'b0;
                r_head             <= ~r_head;
            end
            case ({w_push_acc, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port owner: ALU results win the port, in-order load returns fill the gaps.
module reg_writeback #(
    parameter int LQ_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 alu_we,
    input  logic [reg_writeback_pkg::REG_AW-1:0] alu_rd,
    input  logic [reg_writeback_pkg::XLEN-1:0]   alu_data,
    input  logic                                 ld_issue,
    input  logic [reg_writeback_pkg::REG_AW-1:0] ld_rd,
    output logic                                 ld_ready,
    input  logic                                 ld_rsp_valid,
    input  logic [reg_writeback_pkg::XLEN-1:0]   ld_rsp_data,
    output logic                                 w_we,
    output logic [reg_writeback_pkg::REG_AW-1:0] w_addr,
    output logic [reg_writeback_pkg::XLEN-1:0]   w_data,
    output logic [31:0]                          busy,
    output logic                                 ld_err
);

    import reg_writeback_pkg::*;

    lq_entry_t         w_head;
    logic              w_young_valid;
    logic [REG_AW-1:0] w_young_rd;
    logic              w_lq_ready;
    logic              w_rsp_err;
    logic              w_issue_acc;
    logic              w_pop;
    logic              w_hold_busy;
    logic [31:0]       w_busy_nxt;

    logic              r_we;
    logic [REG_AW-1:0] r_addr;
    logic [XLEN-1:0]   r_data;
    logic [31:0]       r_busy;
    logic              r_err;

    reg_writeback_lq_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk             (clk),
        .rst             (rst),
        .i_push          (ld_issue),
        .i_push_rd       (ld_rd),
        .i_rsp_valid     (ld_rsp_valid),
        .i_rsp_data      (ld_rsp_data),
        .i_pop           (w_pop),
        .o_ready         (w_lq_ready),
        .o_head          (w_head),
        .o_younger_valid (w_young_valid),
        .o_younger_rd    (w_young_rd),
        .o_rsp_err       (w_rsp_err)
    );

    assign ld_ready    = w_lq_ready;
    assign w_issue_acc = ld_issue & w_lq_ready;
    assign w_pop       = ~alu_we & w_head.valid & w_head.filled;

    // Another outstanding load to the same register keeps it busy past this retire.
    assign w_hold_busy = (w_issue_acc && (ld_rd == w_head.rd)) ||
                         (w_young_valid && (w_young_rd == w_head.rd));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop && !w_hold_busy) begin
            w_busy_nxt[w_head.rd] = 1'b0;
        end
        if (w_issue_acc) begin
            w_busy_nxt[ld_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_err  <= r_err | (ld_issue & ~w_lq_ready) | w_rsp_err;
            if (alu_we) begin
                r_we   <= (alu_rd != '0);
                r_addr <= alu_rd;
                r_data <= alu_data;
            end else if (w_pop) begin
                r_we   <= (w_head.rd != '0);
                r_addr <= w_head.rd;
                r_data <= w_head.data;
            end else begin
                r_we   <= 1'b0;
            end
        end
    end

    assign w_we   = r_we;
    assign w_addr = r_addr;
    assign w_data = r_data;
    assign busy   = r_busy;
    assign ld_err = r_err;

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: expected writes queued at stimulus, checked as the port fires.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        ld_ready;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_data;
    logic        w_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] busy;
    logic        ld_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [36:0] exp_q [$];
    logic [36:0] mon_exp;

    always #5 clk = ~clk;

    reg_writeback #(.LQ_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_we       (alu_we),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_issue     (ld_issue),
        .ld_rd        (ld_rd),
        .ld_ready     (ld_ready),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_data  (ld_rsp_data),
        .w_we         (w_we),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .busy         (busy),
        .ld_err       (ld_err)
    );

    // Every register-file write must match the next expected {addr, data} in order.
    always @(negedge clk) begin
        if (w_we === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write", w_addr, w_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({w_addr, w_data} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL wb_order: got addr=%0d data=%h, required addr=%0d data=%h",
                             w_addr, w_data, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_we       = 1'b0;
        alu_rd       = '0;
        alu_data     = '0;
        ld_issue     = 1'b0;
        ld_rd        = '0;
        ld_rsp_valid = 1'b0;
        ld_rsp_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) cyc();
        cyc();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        n_tests++;
        if ({w_we, w_addr, w_data, busy, ld_err, ld_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got we=%b addr=%0d data=%h busy=%h err=%b rdy=%b, required zeros rdy=1",
                     w_we, w_addr, w_data, busy, ld_err, ld_ready);
        end
        alu_we = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        cyc();
        n_tests++;
        if (w_we !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_latency: got w_we=%b, required 1", w_we);
        end
        alu_rd = 5'd0; alu_data = 32'h12345678;
        cyc();
        idle();
        n_tests++;
        if (w_we !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_x0: got w_we=%b, required 0", w_we);
        end
        wait_drain("reset");
    endtask

    task automatic test_single_load();
        ld_issue = 1'b1; ld_rd = 5'd7;
        cyc();
        idle();
        n_tests++;
        if (busy[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_set: got %b, required 1", busy[7]);
        end
        cyc();
        cyc();
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h1234;
        exp_q.push_back({5'd7, 32'h1234});
        cyc();
        idle();
        n_tests++;
        if (busy[7] !== 1'b1 || w_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_fill: got busy7=%b we=%b, required busy7=1 we=0", busy[7], w_we);
        end
        cyc();
        n_tests++;
        if (busy[7] !== 1'b0 || w_we !== 1'b1) begin
            n_fail++;
            $display("FAIL single_retire: got busy7=%b we=%b, required busy7=0 we=1", busy[7], w_we);
        end
        wait_drain("single");
    endtask

    task automatic test_contention();
        ld_issue = 1'b1; ld_rd = 5'd3;
        cyc();
        ld_rd = 5'd11;
        cyc();
        ld_issue = 1'b0;
        n_tests++;
        if (ld_ready !== 1'b0 || busy[3] !== 1'b1 || busy[11] !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_full: got rdy=%b b3=%b b11=%b, required rdy=0 b3=1 b11=1", ld_ready, busy[3], busy[11]);
        end
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h33;
        alu_we = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        exp_q.push_back({5'd4, 32'h44});
        cyc();
        ld_rsp_valid = 1'b0;
        for (int r = 5; r <= 6; r++) begin
            alu_rd = 5'(r); alu_data = 32'(r * 17);
            exp_q.push_back({5'(r), 32'(r * 17)});
            cyc();
        end
        alu_we = 1'b0;
        exp_q.push_back({5'd3, 32'h33});
        n_tests++;
        if (ld_ready !== 1'b0 || busy[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_starved: got rdy=%b b3=%b, required rdy=0 b3=1", ld_ready, busy[3]);
        end
        cyc();
        n_tests++;
        if (ld_ready !== 1'b1 || busy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_pop: got rdy=%b b3=%b, required rdy=1 b3=0", ld_ready, busy[3]);
        end
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'hBB;
        exp_q.push_back({5'd11, 32'hBB});
        cyc();
        idle();
        wait_drain("cont");
    endtask

    task automatic test_full_queue();
        ld_issue = 1'b1; ld_rd = 5'd8;
        cyc();
        ld_rd = 5'd9;
        cyc();
        ld_rd = 5'd12;
        cyc();
        ld_issue = 1'b0;
        n_tests++;
        if (ld_err !== 1'b1 || busy[12] !== 1'b0 || busy[8] !== 1'b1 || busy[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drop: got err=%b b12=%b b8=%b b9=%b, required err=1 b12=0 b8=1 b9=1",
                     ld_err, busy[12], busy[8], busy[9]);
        end
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'hA;
        exp_q.push_back({5'd8, 32'hA});
        cyc();
        ld_rsp_data = 32'hB;
        exp_q.push_back({5'd9, 32'hB});
        cyc();
        idle();
        wait_drain("full");
        n_tests++;
        if (ld_err !== 1'b1) begin
            n_fail++;
            $display("FAIL full_sticky: got err=%b, required 1", ld_err);
        end
    endtask

    task automatic test_x0_same_rd();
        ld_issue = 1'b1; ld_rd = 5'd0;
        cyc();
        ld_rd = 5'd10;
        cyc();
        ld_issue = 1'b0;
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h55;
        cyc();
        ld_rsp_data = 32'h1A;
        cyc();
        ld_rsp_valid = 1'b0;
        n_tests++;
        if (w_we !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_pop: got we=%b b0=%b, required we=0 b0=0", w_we, busy[0]);
        end
        ld_issue = 1'b1; ld_rd = 5'd10;
        exp_q.push_back({5'd10, 32'h1A});
        cyc();
        ld_issue = 1'b0;
        n_tests++;
        if (busy[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL same_rd_issue_hold: got b10=%b, required 1", busy[10]);
        end
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h2B;
        exp_q.push_back({5'd10, 32'h2B});
        cyc();
        ld_rsp_valid = 1'b0;
        cyc();
        n_tests++;
        if (busy[10] !== 1'b0) begin
            n_fail++;
            $display("FAIL same_rd_clear: got b10=%b, required 0", busy[10]);
        end
        wait_drain("x0");
    endtask

    task automatic test_same_rd_queued();
        ld_issue = 1'b1; ld_rd = 5'd13;
        cyc();
        cyc();
        ld_issue = 1'b0;
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'hC0DE0001;
        exp_q.push_back({5'd13, 32'hC0DE0001});
        cyc();
        ld_rsp_data = 32'hC0DE0002;
        exp_q.push_back({5'd13, 32'hC0DE0002});
        cyc();
        ld_rsp_valid = 1'b0;
        n_tests++;
        if (busy[13] !== 1'b1) begin
            n_fail++;
            $display("FAIL queued_hold: got b13=%b, required 1", busy[13]);
        end
        cyc();
        n_tests++;
        if (busy[13] !== 1'b0) begin
            n_fail++;
            $display("FAIL queued_clear: got b13=%b, required 0", busy[13]);
        end
        wait_drain("queued");
    endtask

    task automatic test_errors_reset();
        idle();
        do_reset();
        n_tests++;
        if (ld_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: got err=%b, required 0", ld_err);
        end
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'hBAD0;
        cyc();
        ld_rsp_valid = 1'b0;
        n_tests++;
        if (ld_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_orphan_rsp: got err=%b, required 1", ld_err);
        end
        cyc();
        ld_issue = 1'b1; ld_rd = 5'd20;
        cyc();
        ld_rd = 5'd21;
        cyc();
        ld_issue = 1'b0;
        n_tests++;
        if (ld_ready !== 1'b0 || busy[20] !== 1'b1 || busy[21] !== 1'b1) begin
            n_fail++;
            $display("FAIL err_pending: got rdy=%b b20=%b b21=%b, required rdy=0 b20=1 b21=1", ld_ready, busy[20], busy[21]);
        end
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'hDEAD0020;
        do_reset();
        ld_rsp_valid = 1'b0;
        n_tests++;
        if (busy !== 32'd0 || ld_ready !== 1'b1 || ld_err !== 1'b0 || w_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%h rdy=%b err=%b we=%b, required busy=0 rdy=1 err=0 we=0",
                     busy, ld_ready, ld_err, w_we);
        end
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'hDEAD0021;
        cyc();
        cyc();
        idle();
        cyc();
        cyc();
        n_tests++;
        if (ld_err !== 1'b1 || busy !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_rsp: got err=%b busy=%h, required err=1 busy=0", ld_err, busy);
        end
        wait_drain("errors");
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_single_load();
        test_contention();
        test_full_queue();
        test_x0_same_rd();
        test_same_rd_queued();
        test_errors_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
